// File: rtl/simd_alu_pkg.sv
// ---------------------------------------------------------------------------
// simd_alu_pkg
// Shared types and constants for the SIMD lane sequencer and its ALU.
//   op_e      : 4-bit ALU opcode encoding
//   state_e   : sequencer FSM state encoding
//   N_DEFAULT / LANES_DEFAULT : default lane width and lane count
//   op_is_legal() : true for the defined opcodes 0000..1000
// ---------------------------------------------------------------------------
package simd_alu_pkg;

    localparam int N_DEFAULT     = 16;
    localparam int LANES_DEFAULT = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_DIV = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_SRL = 4'h6,
        OP_SLL = 4'h7,
        OP_ADD = 4'h8
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= 4'h8);
    endfunction

endpackage

// File: rtl/alu_lane_sequencer_alu.sv
// ---------------------------------------------------------------------------
// alu_lane_sequencer_alu
// Single-lane unsigned combinational ALU, arithmetic modulo 2^N.
//   op_i : opcode (op_e encoding); undefined codes pass a_i through
//   a_i  : operand A
//   b_i  : operand B
//   y_o  : result
// ---------------------------------------------------------------------------
module alu_lane_sequencer_alu
    import simd_alu_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [3:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o
);

    localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

    always_comb begin
        y_o = a_i;
        case (op_e'(op_i))
            OP_NOP: y_o = a_i;
            OP_SUB: y_o = a_i - b_i;
            OP_MUL: y_o = a_i * b_i;
            // The sequencer never presents a zero divisor; the guard keeps the
            // block self-contained if reused elsewhere.
            OP_DIV: y_o = (b_i == '0) ? '0 : (a_i / b_i);
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_SRL: y_o = (b_i >= SHIFT_LIMIT) ? '0 : (a_i >> b_i);
            OP_SLL: y_o = (b_i >= SHIFT_LIMIT) ? '0 : (a_i << b_i);
            OP_ADD: y_o = a_i + b_i;
            default: y_o = a_i;
        endcase
    end

endmodule

// File: rtl/alu_lane_sequencer.sv
// ---------------------------------------------------------------------------
// alu_lane_sequencer
// Accepts a LANES-wide vector command and runs it through one shared ALU,
// one lane per clock, then presents the registered result vector.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : command handshake (ready only in IDLE)
//   in_op, in_a, in_b   : opcode and packed operands (lane i at [i*N +: N])
//   out_valid/out_ready : result handshake
//   out_result          : packed lane results
//   out_nop/out_illegal : command was NOP / undefined opcode
//   out_div0            : per-lane divide-by-zero mask
//
// state | meaning
// IDLE  | waiting for a command, in_ready high
// RUN   | processing lane[cnt_q], one lane per clock
// DONE  | result held, out_valid high until out_ready
// ---------------------------------------------------------------------------
module alu_lane_sequencer
    import simd_alu_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int LANES = LANES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [LANES*N-1:0] in_a,
    input  logic [LANES*N-1:0] in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] out_result,
    output logic               out_nop,
    output logic               out_illegal,
    output logic [LANES-1:0]   out_div0
);

    localparam int              CW   = $clog2(LANES);
    localparam logic [CW-1:0]   LAST = CW'(LANES - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [LANES*N-1:0] a_q, a_d;
    logic [LANES*N-1:0] b_q, b_d;
    logic [LANES*N-1:0] res_q, res_d;
    logic               nop_q, nop_d;
    logic               ill_q, ill_d;
    logic [LANES-1:0]   div0_q, div0_d;

    int                 lane_idx;
    logic [N-1:0]       lane_a;
    logic [N-1:0]       lane_b;
    logic [N-1:0]       alu_b;
    logic [N-1:0]       alu_y;
    logic [N-1:0]       lane_y;
    logic               op_legal;
    logic               lane_div0;

    always_comb begin
        lane_idx  = int'(cnt_q);
        lane_a    = a_q[lane_idx*N +: N];
        lane_b    = b_q[lane_idx*N +: N];
        op_legal  = op_is_legal(op_q);
        lane_div0 = (op_q == OP_DIV) && (lane_b == '0);
        // Substitute a harmless divisor so a zero never reaches the ALU.
        alu_b     = lane_div0 ? N'(1) : lane_b;
        if (!op_legal || (op_q == OP_NOP)) begin
            lane_y = lane_a;
        end else if (lane_div0) begin
            lane_y = '0;
        end else begin
            lane_y = alu_y;
        end
    end

    alu_lane_sequencer_alu #(
        .N (N)
    ) u_alu (
        .op_i (op_q),
        .a_i  (lane_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        nop_d   = nop_q;
        ill_d   = ill_q;
        div0_d  = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = '0;
                    nop_d   = 1'b0;
                    ill_d   = 1'b0;
                    div0_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[lane_idx*N +: N] = lane_y;
                if (lane_div0) begin
                    div0_d[lane_idx] = 1'b1;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    nop_d   = (op_q == OP_NOP);
                    ill_d   = !op_legal;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // in_ready is low here, so a coincident in_valid is left
                // pending and accepted from IDLE on the following clock.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            nop_q   <= 1'b0;
            ill_q   <= 1'b0;
            div0_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            nop_q   <= nop_d;
            ill_q   <= ill_d;
            div0_q  <= div0_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign out_result  = res_q;
    assign out_nop     = nop_q;
    assign out_illegal = ill_q;
    assign out_div0    = div0_q;

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_lane_sequencer
// Scoreboarded bench for alu_lane_sequencer (N=16, LANES=4): directed
// scenarios plus randomized commands checked against a lane-wise
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_lane_sequencer;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int W     = N * LANES;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_nop;
    logic         out_illegal;
    logic [3:0]   out_div0;

    alu_lane_sequencer #(.N(N), .LANES(LANES)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_nop     (out_nop),
        .out_illegal (out_illegal),
        .out_div0    (out_div0)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         nop;
        logic         ill;
        logic [3:0]   div0;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic pv       = 1'b0;
    bit   manual   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Random consumer back-pressure unless a directed test takes over.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!manual) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [W-1:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    function automatic exp_t mk(input logic [W-1:0] r, input logic n, input logic il,
                                input logic [3:0] d);
        exp_t e;
        e.res = r; e.nop = n; e.ill = il; e.div0 = d; e.acc = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic per lane, reduced modulo 2^16.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t e;
        e.res = '0; e.div0 = '0; e.acc = 0;
        e.nop = (op == 4'd0);
        e.ill = (op > 4'd8);
        for (int i = 0; i < LANES; i++) begin
            longint x, y, r;
            x = a[i*N +: N];
            y = b[i*N +: N];
            case (op)
                4'd1: r = x - y + 65536;
                4'd2: r = x * y;
                4'd3: begin
                    if (y == 0) begin r = 0; e.div0[i] = 1'b1; end
                    else r = x / y;
                end
                4'd4: r = x & y;
                4'd5: r = x | y;
                4'd6: r = (y >= 16) ? 0 : (x >> y);
                4'd7: r = (y >= 16) ? 0 : (x << y);
                4'd8: r = x + y;
                default: r = x;
            endcase
            e.res[i*N +: N] = 16'(r % 65536);
        end
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Offer a command, wait (bounded) for acceptance, then scramble inputs.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
        int t;
        @(posedge clk);
        #2;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("accept_timeout", (t >= 200), 0);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_op    = 4'($urandom());
        in_a     = {$urandom(), $urandom()};
        in_b     = {$urandom(), $urandom()};
    endtask

    task automatic send_rand();
        logic [3:0]   op;
        logic [W-1:0] a, b;
        op = 4'($urandom_range(0, 15));
        a  = {$urandom(), $urandom()};
        for (int i = 0; i < LANES; i++)
            b[i*N +: N] = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20))
                                                      : 16'($urandom());
        send(op, a, b, model(op, a, b));
    endtask

    // Monitor: latency on out_valid rise, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (rst) begin
            pv = 1'b0;
        end else begin
            if (out_valid) chk("in_ready_low_in_done", in_ready, 0);
            if (out_valid && !pv) begin
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("latency", cyc - sb[0].acc, LANES);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("nop", out_nop, e.nop);
                    chk("illegal", out_illegal, e.ill);
                    chk("div0", out_div0, e.div0);
                end
            end
            pv = out_valid;
        end
    end

    initial begin
        logic [W-1:0] snap;
        logic [5:0]   snap_f;
        int t;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_flags", {out_nop, out_illegal, out_div0}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        send(4'h8, 64'hFFFF_0003_0002_0001, rep(16'h0001),
             mk(64'h0000_0004_0003_0002, 0, 0, 4'b0000));
        send(4'h3, rep(16'd100), 64'h0003_0000_000A_0005,
             mk(64'h0021_0000_000A_0014, 0, 0, 4'b0100));
        send(4'h1, rep(16'd3), rep(16'd5), mk(rep(16'hFFFE), 0, 0, 0));
        send(4'h7, rep(16'd1), rep(16'd15), mk(rep(16'h8000), 0, 0, 0));
        send(4'h6, rep(16'h1234), rep(16'd16), mk('0, 0, 0, 0));
        send(4'h2, rep(16'h0100), rep(16'h0100), mk('0, 0, 0, 0));
        send(4'hA, 64'h0004_0003_0002_0001, 64'h1111_2222_3333_4444,
             mk(64'h0004_0003_0002_0001, 0, 1, 0));
        send(4'h0, 64'hDEAD_BEEF_0123_4567, 64'h5555_5555_5555_5555,
             mk(64'hDEAD_BEEF_0123_4567, 1, 0, 0));

        // Back-pressure: hold out_ready low for 10 clocks in DONE.
        t = 0;
        while (sb.size() != 0 && t < 200) begin @(posedge clk); t++; end
        chk("drain_before_bp", sb.size(), 0);
        @(posedge clk);
        #2;
        manual = 1'b1;
        out_ready = 1'b0;
        send(4'h4, 64'hF0F0_FF00_1234_AAAA, 64'h0FF0_F0F0_FFFF_00FF,
             mk(64'h00F0_F000_1234_00AA, 0, 0, 0));
        t = 0;
        do begin @(negedge clk); t++; end while (!out_valid && t < 50);
        chk("bp_valid_timeout", (t >= 50), 0);
        snap   = out_result;
        snap_f = {out_nop, out_illegal, out_div0};
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_held", out_valid, 1);
            chk("bp_result_held", out_result, snap);
            chk("bp_flags_held", {out_nop, out_illegal, out_div0}, snap_f);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 4'h5;
        in_a = 64'h1000_0200_0030_0004; in_b = 64'h0001_0010_0100_1000;
        begin
            exp_t e;
            e = mk(64'h1001_0210_0130_1004, 0, 0, 0);
            e.acc = cyc + 2;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        chk("done_no_accept", in_ready, 1);
        @(posedge clk);
        #2;
        chk("accept_next_clock", in_ready, 0);
        in_valid = 1'b0;
        manual = 1'b0;

        // Reset while the counter is at lane 2.
        t = 0;
        while (sb.size() != 0 && t < 200) begin @(posedge clk); t++; end
        chk("drain_before_rst", sb.size(), 0);
        send(4'h8, rep(16'd7), rep(16'd9), mk(rep(16'd16), 0, 0, 0));
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrun_rst_valid", out_valid, 0);
        chk("midrun_rst_ready", in_ready, 1);
        chk("midrun_rst_result", out_result, 0);
        @(negedge clk);
        rst = 1'b0;
        send(4'h8, 64'h0010_0020_0030_FFFF, 64'h0001_0002_0003_0002,
             mk(64'h0011_0022_0033_0001, 0, 0, 0));

        for (int k = 0; k < 40; k++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        end

        t = 0;
        while (sb.size() != 0 && t < 500) begin @(posedge clk); t++; end
        chk("final_drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
